// File: rtl/bcd_share_arbiter_pkg.sv
// Shared definitions for the BCD converter share arbiter:
// FSM encoding, saturation constants and packed-digit helpers.
package bcd_share_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [31:0] BCD_MAX_BIN = 32'd99_999_999;
   localparam logic [31:0] BCD_SAT     = 32'h9999_9999;

   // Digit k of a packed BCD word lives at [4k+3:4k].
   function automatic logic [3:0] bcd_digit(input logic [31:0] w,
                                            input int k);
      return w[4*k +: 4];
   endfunction

   // Operands above eight decimal digits saturate so the
   // converter never yields an invalid nibble.
   function automatic logic [31:0] clamp_bin(input logic [31:0] b);
      return (b > BCD_MAX_BIN) ? BCD_MAX_BIN : b;
   endfunction

endpackage

// File: rtl/bcd_share_arbiter_rr_pick.sv
// Combinational round-robin selector (rr_pick).
// Ports: req (request vector), last (previous winner) -> sel, any.
module bcd_share_arbiter_rr_pick #(
   parameter int NUM_CH = 4
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [2:0]        last,
   output logic [2:0]        sel,
   output logic              any
);

   logic [2:0] lo_sel;
   logic [2:0] hi_sel;
   logic       lo_any;
   logic       hi_any;

   // Lowest set bit above last wins; otherwise wrap to the
   // lowest set bit overall. Descending scan keeps the lowest.
   always_comb begin
      lo_sel = '0;
      hi_sel = '0;
      lo_any = 1'b0;
      hi_any = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo_sel = 3'(i);
            lo_any = 1'b1;
            if (3'(i) > last) begin
               hi_sel = 3'(i);
               hi_any = 1'b1;
            end
         end
      end
      sel = hi_any ? hi_sel : lo_sel;
      any = lo_any;
   end

endmodule

// File: rtl/bcd_share_arbiter.sv
// Time-shares one external binary-to-BCD converter among NUM_CH
// requesters (req/ack), caching each channel's packed BCD.
// Ports: clk, rst (sync, active-high), req, value, ack, conv_bin,
//        conv_bcd, digits, grant_id, busy.
module bcd_share_arbiter
   import bcd_share_arbiter_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int SETTLE = 2,
   parameter int CNT_W  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_CH-1:0]    req,
   input  logic [NUM_CH*32-1:0] value,
   output logic [NUM_CH-1:0]    ack,
   output logic [31:0]          conv_bin,
   input  logic [31:0]          conv_bcd,
   output logic [NUM_CH*32-1:0] digits,
   output logic [2:0]           grant_id,
   output logic                 busy
);

   state_t            state;
   state_t            state_n;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_n;
   logic [2:0]        last;
   logic [2:0]        last_n;
   logic [2:0]        grant_n;
   logic [31:0]       bin_n;
   logic [NUM_CH-1:0] ack_n;
   logic              cap;
   logic [2:0]        sel;
   logic              any;
   logic [31:0]       op;

   bcd_share_arbiter_rr_pick #(
      .NUM_CH(NUM_CH)
   ) u_pick (
      .req (req),
      .last(last),
      .sel (sel),
      .any (any)
   );

   always_comb begin
      op = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sel == 3'(i)) op = value[i*32 +: 32];
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      last_n  = last;
      grant_n = grant_id;
      bin_n   = conv_bin;
      ack_n   = '0;
      cap     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (any) begin
               grant_n = sel;
               last_n  = sel;
               bin_n   = clamp_bin(op);
               cnt_n   = CNT_W'(SETTLE - 1);
               state_n = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt != '0) begin
               cnt_n = cnt - CNT_W'(1);
            end else begin
               cap = 1'b1;
               for (int i = 0; i < NUM_CH; i++) begin
                  ack_n[i] = (grant_id == 3'(i));
               end
               state_n = ST_DONE;
            end
         end
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         last     <= 3'(NUM_CH - 1);
         grant_id <= '0;
         conv_bin <= '0;
         ack      <= '0;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         last     <= last_n;
         grant_id <= grant_n;
         conv_bin <= bin_n;
         ack      <= ack_n;
         busy     <= (state_n != ST_IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digits <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (cap && grant_id == 3'(i)) begin
               digits[i*32 +: 32] <= conv_bcd;
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_share_arbiter.sv
// Testbench for bcd_share_arbiter: behavioural converter plus a
// transaction-timeline reference model, directed and random stimulus.
module tb_bcd_share_arbiter;
   import bcd_share_arbiter_pkg::*;

   localparam int NUM_CH = 4;
   localparam int SETTLE = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NUM_CH-1:0]    req;
   logic [NUM_CH*32-1:0] value;
   logic [NUM_CH-1:0]    ack;
   logic [31:0]          conv_bin;
   logic [31:0]          conv_bcd;
   logic [NUM_CH*32-1:0] digits;
   logic [2:0]           grant_id;
   logic                 busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bcd_share_arbiter #(
      .NUM_CH(NUM_CH),
      .SETTLE(SETTLE),
      .CNT_W (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .value   (value),
      .ack     (ack),
      .conv_bin(conv_bin),
      .conv_bcd(conv_bcd),
      .digits  (digits),
      .grant_id(grant_id),
      .busy    (busy)
   );

   function automatic logic [31:0] to_bcd(input logic [31:0] b);
      int unsigned d;
      logic [31:0] r;
      d = b;
      r = '0;
      for (int k = 0; k < 8; k++) begin
         r[4*k +: 4] = 4'(d % 10);
         d = d / 10;
      end
      return r;
   endfunction

   assign conv_bcd = to_bcd(conv_bin);

   // Reference model: m_rem counts cycles left in the current service.
   int          m_rem;
   int          m_last;
   int          m_grant;
   int          m_ack;
   logic [31:0] m_bin;
   logic [31:0] m_dig [NUM_CH];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      int c;
      logic [31:0] v;
      if (rst) begin
         m_rem = 0; m_last = NUM_CH - 1; m_grant = 0;
         m_ack = -1; m_bin = '0;
         for (int i = 0; i < NUM_CH; i++) m_dig[i] = '0;
      end else if (m_rem == 0) begin
         m_ack = -1;
         for (int k = 1; k <= NUM_CH; k++) begin
            c = (m_last + k) % NUM_CH;
            if (m_rem == 0 && req[c]) begin
               v = value[32*c +: 32];
               m_bin = (v > 32'd99_999_999) ? 32'd99_999_999 : v;
               m_grant = c;
               m_last = c;
               m_rem = SETTLE + 1;
            end
         end
      end else begin
         m_rem--;
         if (m_rem == 1) begin
            m_dig[m_grant] = to_bcd(m_bin);
            m_ack = m_grant;
         end else begin
            m_ack = -1;
         end
      end
   endtask

   task automatic compare();
      logic [31:0] ea;
      ea = (m_ack < 0) ? 32'd0 : (32'd1 << m_ack);
      chk("ack", 32'(ack), ea);
      chk("busy", 32'(busy), 32'(m_rem != 0));
      chk("grant_id", 32'(grant_id), 32'(m_grant));
      chk("conv_bin", conv_bin, m_bin);
      for (int i = 0; i < NUM_CH; i++)
         chk("digits", digits[32*i +: 32], m_dig[i]);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic serve(input int ch, input logic [31:0] v);
      int n;
      value[32*ch +: 32] = v;
      req[ch] = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (m_ack != ch && n < 40);
      req[ch] = 1'b0;
   endtask

   function automatic logic [31:0] rand_val();
      case ($urandom_range(0, 4))
         0: return 32'd0;
         1: return BCD_MAX_BIN;
         2: return BCD_MAX_BIN + 32'd1;
         3: return $urandom;
         default: return 32'($urandom_range(0, 99_999_999));
      endcase
   endfunction

   initial begin
      rst = 1'b1;
      req = '0;
      value = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Single request latency and cache write.
      serve(1, 32'd12345);
      chk("single_dig", digits[63:32], 32'h0001_2345);
      tick();

      // All requests held: round-robin from ch0.
      do_reset();
      for (int i = 0; i < NUM_CH; i++)
         value[32*i +: 32] = 32'(1000 * (i + 1) + i);
      req = '1;
      for (int i = 0; i < 20; i++) tick();
      req = '0;
      for (int i = 0; i < 4; i++) tick();

      // Saturation boundaries on ch2.
      serve(2, 32'd100_000_000);
      chk("sat_over", digits[95:64], BCD_SAT);
      serve(2, BCD_MAX_BIN);
      chk("sat_max", digits[95:64], BCD_SAT);
      serve(2, 32'd0);
      chk("sat_zero", digits[95:64], 32'd0);
      tick();

      // Reset one cycle after grant on ch3 aborts the conversion.
      do_reset();
      value[127:96] = 32'd4321;
      req[3] = 1'b1;
      tick();
      tick();
      do_reset();
      for (int i = 0; i < 4; i++) tick();
      value[31:0] = 32'd77;
      req = 4'b1001;
      for (int i = 0; i < 3; i++) tick();
      chk("rst_first", 32'(ack), 32'b0001);
      req[0] = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      req = '0;
      for (int i = 0; i < 4; i++) tick();

      // Operand change during WAIT is ignored.
      value[63:32] = 32'd555;
      req[1] = 1'b1;
      tick();
      value[63:32] = 32'd777;
      tick();
      tick();
      chk("hold_op", digits[63:32], 32'h0000_0555);
      req[1] = 1'b0;
      tick();

      // Random traffic, occasional reset and post-grant operand changes.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 499) == 0);
         for (int i = 0; i < NUM_CH; i++) begin
            if (!req[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  value[32*i +: 32] = rand_val();
                  req[i] = 1'b1;
               end
            end else if (m_ack == i) begin
               if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
            end else if (m_rem > 1 && m_grant == i) begin
               if ($urandom_range(0, 7) == 0)
                  value[32*i +: 32] = rand_val();
            end
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_share_arbiter.md
Name: bcd_share_arbiter

Overview:
- Time-shares one combinational binary-to-BCD converter between several HUD requesters: score, coins, timer and world/lives.
- Each requester is served round-robin over a req/ack handshake.
- The block drives the converter input from a register and waits a fixed number of settle cycles. It then captures the 8-digit packed BCD result into a per-channel cache, which the seven-segment and HUD renderers read directly.

Parameters:
- NUM_CH, 4, number of requesters (2..8).
- SETTLE, 2, cycles the converter input is held before the result is captured (≥1; covers converter combinational depth).
- CNT_W, 2, width of the settle counter (≥ clog2(SETTLE)).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- req  in  NUM_CH  per-channel conversion request, level; must stay high until ack.
- value  in  NUM_CH*32  per-channel binary operand; channel i occupies bits [32i+31:32i]; must be stable while req[i]=1.
- ack  out  NUM_CH  one-cycle, one-hot pulse: conversion for that channel is done and its cache is updated.
- conv_bin  out  32  registered operand driven to the shared converter.
- conv_bcd  in  32  converter result, packed {bcd7..bcd0}, bcd0 at [3:0].
- digits  out  NUM_CH*32  cached packed BCD per channel, same slicing as value.
- grant_id  out  3  channel currently or last served.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset: clk is the single clock; rst is synchronous, active-high.
  - state=IDLE; conv_bin=0; ack=0; digits=0 for all channels; grant_id=0; counter=0.
  - Round-robin pointer last=NUM_CH-1, so channel 0 has first priority.
  - Reset asserted mid-conversion aborts it: no ack, no cache write.
- IDLE:
  - If any req bit is high at a clock edge, select the first set bit searching last+1, last+2, …, wrapping modulo NUM_CH.
  - At that edge: grant_id←sel, last←sel, conv_bin←clamp(value[sel]), counter←SETTLE-1, state←WAIT.
  - If no req bit is high, the block stays in IDLE.
- clamp:
  - Operands > 99_999_999 are replaced by 99_999_999, so the cache shows 0x9999_9999 and never an invalid nibble.
  - Operands ≤ 99_999_999 pass through unchanged.
- WAIT:
  - If counter≠0, decrement it.
  - If counter=0, at that edge: digits[grant_id]←conv_bcd, ack←onehot(grant_id), state←DONE.
  - WAIT lasts exactly SETTLE cycles.
- DONE:
  - Lasts one cycle; ack is high during this cycle.
  - At the next edge: ack←0, state←IDLE.
  - req is ignored in DONE, so a requester dropping req after seeing ack is never double-served.
- Latency: with req[i] high at edge E0 while IDLE and no contention, ack[i] is high in the cycle after edge E0+SETTLE. For SETTLE=2 that is 3 edges, and service throughput is SETTLE+2 cycles.
- Fairness:
  - With all requests held high, channels are served in order last+1, last+2, …; no channel waits more than NUM_CH-1 services.
  - A requester arriving mid-conversion waits and is arbitrated at the next IDLE edge.
- Dropped or changed operands:
  - If req drops mid-conversion, the conversion completes, the cache updates and ack still pulses.
  - value changes after grant are ignored, because conv_bin is registered at grant.
- Cache holding: digits slices hold their values indefinitely; only the granted slice is written, at the WAIT→DONE edge.
- Output timing: ack is at most one-hot; ack, conv_bin, digits, grant_id and busy are all registered.

Decomposition:
- Shared package contents:
  - State encoding IDLE/WAIT/DONE (2-bit).
  - BCD_MAX_BIN = 32'd99_999_999.
  - BCD_SAT = 32'h9999_9999.
  - Packed-digit slice helpers (digit k at [4k+3:4k]).
- One sub-module: rr_pick, a combinational round-robin selector.
  - Inputs: req vector, last pointer.
  - Outputs: sel index, any.
  - Reused by other shared-resource controllers in the design.
- The converter itself stays outside; the testbench instantiates it and connects conv_bin/conv_bcd.

Test Plan:
- Single request, SETTLE=2: req[1]=1, value[1]=12345 at E0 → ack[1] high only in the cycle after E2; digits[1]=0x0001_2345; busy high for 3 cycles; other cache slots stay 0.
- All four req high, held, channels acked in turn: ack order is ch0, ch1, ch2, ch3, ch0, …; consecutive acks are exactly 4 cycles apart; each cache slot shows its own operand's BCD.
- Saturation:
  - value[2]=100_000_000 → digits[2]=0x9999_9999.
  - value[2]=99_999_999 → also 0x9999_9999.
  - value[2]=0 → 0x0000_0000.
- Reset mid-WAIT: assert rst one cycle after grant on ch3 → no ack ever; all digits=0; the next request to ch0 is served first (last pointer reset).
- Held request and operand change:
  - ch0 keeps req high for 2 cycles after its ack → exactly one ack, then re-served only after the other pending channels.
  - value changed during WAIT → cache holds the grant-time operand's BCD.
